fpu_mul_arbiter: RTL

FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

---
 rtl/fpu_mul_arbiter_pkg.sv | 20 ++
 rtl/fpu_rr_picker.sv | 26 ++
 rtl/fpu_mul_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fpu_mul_arbiter_pkg.sv
// Shared types for the fp16 multiplier arbiter: operand/condition types, FSM states, qNaN.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_lib;

  typedef logic [15:0] fp16_t;
  typedef logic [3:0]  condCode_t;

  typedef enum logic [2:0] {
    ARB_IDLE  = 3'd0,
    ARB_ISSUE = 3'd1,
    ARB_WAIT  = 3'd2,
    ARB_RESP  = 3'd3,
    ARB_CLEAR = 3'd4
  } fpuArbState_t;

  // Canonical quiet NaN returned when the multiplier never answers.
  localparam fp16_t FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/fpu_rr_picker.sv
// Round-robin picker: first valid requester after `last`, wrapping at NREQ.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module fpu_rr_picker #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] grant,
  output logic                    any
);

  localparam int GW = $clog2(NREQ);

  // Scan from the farthest offset down so the nearest valid index after `last` wins.
  always_comb begin
    grant = '0;
    any   = |valid;
    for (int i = NREQ; i >= 1; i--) begin
      if (valid[(int'(last) + i) % NREQ]) begin
        grant = GW'((int'(last) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one fp16 multiplier between NREQ requesters: accept, issue, wait, respond, re-arm.
// Latency: accept at T, mulStart at T+1, response at T+2+k (k = cycles to mulDone, capped at MAX_WAIT).
// Backpressure: one operation in flight; requests stay pending while busy, RESP holds until rspReady.
module fpu_mul_arbiter
  import fpu_lib::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_WAIT = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         reqValid,
  input  logic [NREQ*16-1:0]      reqOp1,
  input  logic [NREQ*16-1:0]      reqOp2,
  output logic [NREQ-1:0]         reqReady,
  output logic [NREQ-1:0]         rspValid,
  input  logic [NREQ-1:0]         rspReady,
  output logic [15:0]             rspData,
  output logic [3:0]              rspCond,
  output logic                    rspErr,
  output logic [15:0]             mulIn1,
  output logic [15:0]             mulIn2,
  output logic                    mulStart,
  output logic                    mulClear,
  input  logic [15:0]             mulOut,
  input  logic [3:0]              mulCond,
  input  logic                    mulDone,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grantId
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_WAIT + 1);

  fpuArbState_t  state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] pick;
  logic          any_valid;
  fp16_t         op1_q;
  fp16_t         op2_q;
  fp16_t         res_data;
  condCode_t     res_cond;
  logic          res_err;
  logic [CW-1:0] wait_cnt;
  logic          timeout;

  // Last allowed WAIT cycle: the counter has already seen MAX_WAIT-1 cycles go by.
  assign timeout = (wait_cnt == CW'(MAX_WAIT - 1));

  fpu_rr_picker #(.NREQ(NREQ)) u_picker (
    .valid (reqValid),
    .last  (last_grant),
    .grant (pick),
    .any   (any_valid)
  );

  // Operation sequencer: grant, issue, wait for result or timeout, hand back, re-arm multiplier.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ARB_IDLE;
      last_grant <= GW'(NREQ - 1);
      grant_q    <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      wait_cnt   <= '0;
      res_data   <= '0;
      res_cond   <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_valid) begin
            grant_q <= pick;
            op1_q   <= reqOp1[pick*16 +: 16];
            op2_q   <= reqOp2[pick*16 +: 16];
            state   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          wait_cnt <= '0;
          state    <= ARB_WAIT;
        end
        ARB_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (mulDone) begin
            res_data <= mulOut;
            res_cond <= mulCond;
            res_err  <= 1'b0;
            state    <= ARB_RESP;
          end else if (timeout) begin
            res_data <= FP16_QNAN;
            res_cond <= '0;
            res_err  <= 1'b1;
            state    <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (rspReady[grant_q]) begin
            state <= ARB_CLEAR;
          end
        end
        ARB_CLEAR: begin
          last_grant <= grant_q;
          state      <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign reqReady = (state == ARB_IDLE && any_valid) ? (NREQ'(1) << pick) : '0;
  assign rspValid = (state == ARB_RESP) ? (NREQ'(1) << grant_q) : '0;
  assign mulStart = (state == ARB_ISSUE);
  // Reset also re-arms the multiplier so an aborted operation cannot leak a late mulDone.
  assign mulClear = !reset_n || (state == ARB_CLEAR);
  assign busy     = (state != ARB_IDLE);
  assign grantId  = grant_q;
  assign mulIn1   = op1_q;
  assign mulIn2   = op2_q;
  assign rspData  = res_data;
  assign rspCond  = res_cond;
  assign rspErr   = res_err;

endmodule
